// File: rtl/sprite_line_scheduler_if.sv
// Bundle of the scheduler's control, attribute-table, sprite-ROM and
// line-RAM signals. The slave modport is the scheduler's view; the master
// modport is the view of whatever drives it (CPU side, ROM, sequencer).
interface sprite_line_scheduler_if #(
    parameter int IDX_W = 3
);
    logic             line_start;
    logic [9:0]       next_row;
    logic             buf_sel;
    logic             attr_we;
    logic [IDX_W-1:0] attr_addr;
    logic [26:0]      attr_wdata;
    logic [5:0]       rom_sprite;
    logic [2:0]       rom_row;
    logic [2:0]       rom_col;
    logic [1:0]       rom_pixel;
    logic             lr_write;
    logic [10:0]      lr_addr;
    logic [1:0]       lr_data;
    logic             busy;
    logic             done;
    logic             overflow;

    modport slave (
        input  line_start, next_row, buf_sel, attr_we, attr_addr, attr_wdata, rom_pixel,
        output rom_sprite, rom_row, rom_col, lr_write, lr_addr, lr_data, busy, done, overflow
    );

    modport master (
        output line_start, next_row, buf_sel, attr_we, attr_addr, attr_wdata, rom_pixel,
        input  rom_sprite, rom_row, rom_col, lr_write, lr_addr, lr_data, busy, done, overflow
    );
endinterface

// File: rtl/sprite_line_scheduler.sv
// Sprite scanline builder: on each line_start it clears one half of the
// ping-pong line RAM, walks the sprite attribute table in index order and
// renders up to MAX_PER_LINE sprites that intersect the captured row.
// Later table entries paint over earlier ones; ROM pixel 0 is transparent.
module sprite_line_scheduler #(
    parameter int NUM_SPRITES  = 8,
    parameter int IDX_W        = 3,
    parameter int MAX_PER_LINE = 4
) (
    input  logic i_Clk,
    input  logic reset,
    sprite_line_scheduler_if.slave bus
);
    localparam int               CNT_W    = $clog2(MAX_PER_LINE + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PER_LINE);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SCAN  = 3'd2,
        ST_FETCH = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [26:0]      attr_q [NUM_SPRITES];
    logic [26:0]      attr_d [NUM_SPRITES];
    logic [9:0]       row_q, row_d;
    logic             buf_q, buf_d;
    logic [7:0]       k_q, k_d;          // clear address in CLEAR, column in FETCH/DRAIN
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       num_q, num_d;
    logic [2:0]       dyr_q, dyr_d;
    logic [7:0]       xb_q, xb_d;
    logic [2:0]       rom_col_q, rom_col_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [26:0]      entry_s;
    logic [9:0]       dy_s;
    logic             hit_s;
    logic             lr_write_s;
    logic [10:0]      lr_addr_s;
    logic [1:0]       lr_data_s;
    logic [7:0]       pix_col_s;
    logic             unused_s;

    // Live attribute entry under the scan index and its row-intersection test.
    always_comb begin
        entry_s  = attr_q[idx_q];
        dy_s     = row_q - entry_s[19:10];
        hit_s    = entry_s[26] && (dy_s < 10'd16);
        unused_s = ^{entry_s[9], entry_s[0]};
    end

    // CPU write port into the attribute table, usable in any state.
    always_comb begin
        attr_d = attr_q;
        if (bus.attr_we) begin
            attr_d[bus.attr_addr] = bus.attr_wdata;
        end else begin
            attr_d = attr_q;
        end
    end

    // Build sequencer: next state, counters, latched sprite and status flags.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        buf_d      = buf_q;
        k_d        = k_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        num_d      = num_q;
        dyr_d      = dyr_q;
        xb_d       = xb_q;
        rom_col_d  = rom_col_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                if (k_q == 8'd255) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    k_d     = 8'd0;
                end else begin
                    k_d = k_q + 8'd1;
                end
            end
            ST_SCAN: begin
                if (hit_s && (cnt_q < MAX_CNT)) begin
                    num_d     = entry_s[25:20];
                    dyr_d     = dy_s[3:1];
                    xb_d      = entry_s[8:1];
                    cnt_d     = cnt_q + CNT_W'(1);
                    k_d       = 8'd0;
                    rom_col_d = 3'd0;
                    state_d   = ST_FETCH;
                end else begin
                    if (hit_s) begin
                        overflow_d = 1'b1;
                    end else begin
                        overflow_d = overflow_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_FETCH: begin
                // k runs 0..7 here and lands on 8 in DRAIN, so k-1 is always
                // the column whose pixel is arriving from the ROM.
                k_d = k_q + 8'd1;
                if (k_q[2:0] == 3'd7) begin
                    state_d = ST_DRAIN;
                end else begin
                    rom_col_d = k_q[2:0] + 3'd1;
                end
            end
            ST_DRAIN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_SCAN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new line always wins, including over a build still in flight.
        if (bus.line_start) begin
            state_d    = ST_CLEAR;
            row_d      = bus.next_row;
            buf_d      = bus.buf_sel;
            k_d        = 8'd0;
            idx_d      = '0;
            cnt_d      = '0;
            overflow_d = 1'b0;
            done_d     = 1'b0;
        end else begin
            row_d = row_d;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Line-RAM write port: clear sweep, then one cycle-late pixel writes.
    always_comb begin
        lr_write_s = 1'b0;
        lr_addr_s  = 11'd0;
        lr_data_s  = 2'd0;
        pix_col_s  = xb_q + (k_q - 8'd1);
        case (state_q)
            ST_CLEAR: begin
                lr_write_s = 1'b1;
                lr_addr_s  = {2'b00, buf_q, k_q};
                lr_data_s  = 2'd0;
            end
            ST_FETCH, ST_DRAIN: begin
                if ((state_q == ST_DRAIN) || (k_q != 8'd0)) begin
                    lr_write_s = (bus.rom_pixel != 2'd0);
                    lr_addr_s  = {2'b00, buf_q, pix_col_s};
                    lr_data_s  = bus.rom_pixel;
                end else begin
                    lr_write_s = 1'b0;
                end
            end
            default: begin
                lr_write_s = 1'b0;
            end
        endcase
    end

    // State and table registers with synchronous reset.
    always_ff @(posedge i_Clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            attr_q     <= '{default: 27'd0};
            row_q      <= 10'd0;
            buf_q      <= 1'b0;
            k_q        <= 8'd0;
            idx_q      <= '0;
            cnt_q      <= '0;
            num_q      <= 6'd0;
            dyr_q      <= 3'd0;
            xb_q       <= 8'd0;
            rom_col_q  <= 3'd0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            attr_q     <= attr_d;
            row_q      <= row_d;
            buf_q      <= buf_d;
            k_q        <= k_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            num_q      <= num_d;
            dyr_q      <= dyr_d;
            xb_q       <= xb_d;
            rom_col_q  <= rom_col_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.rom_sprite = num_q;
    assign bus.rom_row    = dyr_q;
    assign bus.rom_col    = rom_col_q;
    assign bus.lr_write   = lr_write_s;
    assign bus.lr_addr    = lr_addr_s;
    assign bus.lr_data    = lr_data_s;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Bench for sprite_line_scheduler: a line-level model predicts, per cycle,
// every line-RAM write, ROM address, busy/done/overflow and the final
// contents of the built half; directed tests add literal spot checks.
module tb_sprite_line_scheduler;
    localparam int NUM  = 8;
    localparam int MAXL = 4;
    localparam int NEVER = 32'h7fffffff;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   errors = 0;
    int   checks = 0;
    int   done_seen = 0;

    sprite_line_scheduler_if #(.IDX_W(3)) sl_if ();

    sprite_line_scheduler #(.NUM_SPRITES(NUM), .IDX_W(3), .MAX_PER_LINE(MAXL)) dut (
        .i_Clk (clk),
        .reset (reset),
        .bus   (sl_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] rom_f(logic [5:0] s, logic [2:0] r, logic [2:0] c);
        logic [1:0] v;
        v = s[1:0] + r[1:0] + c[1:0];
        return v;
    endfunction

    // Synchronous sprite ROM: data for the address seen at an edge appears after it.
    always @(posedge clk) sl_if.rom_pixel <= rom_f(sl_if.rom_sprite, sl_if.rom_row, sl_if.rom_col);

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- line-level model ----------------
    logic [26:0] tbl [NUM];
    logic [12:0] exp_wr [int];   // {addr, data} keyed by cycle
    logic [11:0] exp_rom [int];  // {sprite, row, col} keyed by cycle
    logic [1:0]  mirror  [2048];
    logic [1:0]  exp_ram [2048];
    bit          active = 1'b0;
    bit          started = 1'b0;
    int          t0 = 0, done_cyc = -1, ovf_cyc = NEVER;
    bit          cur_buf = 1'b0;

    task automatic build(int t, logic [9:0] row, logic b);
        logic [26:0] e;
        logic [9:0]  dy;
        logic [7:0]  col8;
        logic [10:0] a;
        logic [1:0]  p;
        int tt, h;
        exp_wr.delete();
        exp_rom.delete();
        t0 = t; cur_buf = b; active = 1'b1; ovf_cyc = NEVER;
        for (int k = 0; k < 256; k++) begin
            a = {2'b00, b, 8'(k)};
            exp_wr[t + 1 + k] = {a, 2'b00};
            exp_ram[a] = 2'd0;
        end
        tt = t + 257; h = 0;
        for (int i = 0; i < NUM; i++) begin
            e  = tbl[i];
            dy = row - e[19:10];
            if (e[26] && dy < 10'd16) begin
                if (h < MAXL) begin
                    for (int c = 0; c < 8; c++) begin
                        col8 = e[8:1] + 8'(c);
                        a = {2'b00, b, col8};
                        p = rom_f(e[25:20], dy[3:1], 3'(c));
                        exp_rom[tt + 1 + c] = {e[25:20], dy[3:1], 3'(c)};
                        if (p != 2'd0) begin
                            exp_wr[tt + 2 + c] = {a, p};
                            exp_ram[a] = p;
                        end
                    end
                    h++;
                    tt += 10;
                end else begin
                    if (ovf_cyc == NEVER) ovf_cyc = tt + 1;
                    tt += 1;
                end
            end else begin
                tt += 1;
            end
        end
        done_cyc = tt;
    endtask

    bit exp_w;
    int bad;
    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (started) begin
            exp_w = exp_wr.exists(cyc);
            chk("lr_write", 32'(sl_if.lr_write), 32'(exp_w));
            if (exp_w) begin
                chk("lr_addr", 32'(sl_if.lr_addr), 32'(exp_wr[cyc][12:2]));
                chk("lr_data", 32'(sl_if.lr_data), 32'(exp_wr[cyc][1:0]));
            end
            chk("busy", 32'(sl_if.busy), 32'(active && cyc > t0 && cyc < done_cyc));
            chk("done", 32'(sl_if.done), 32'(active && cyc == done_cyc));
            chk("overflow", 32'(sl_if.overflow), 32'(active && cyc >= ovf_cyc));
            if (exp_rom.exists(cyc))
                chk("rom_addr", 32'({sl_if.rom_sprite, sl_if.rom_row, sl_if.rom_col}), 32'(exp_rom[cyc]));
            if (sl_if.lr_write === 1'b1 && !$isunknown(sl_if.lr_addr))
                mirror[sl_if.lr_addr] = sl_if.lr_data;
            if (sl_if.done === 1'b1) done_seen++;
            if (active && cyc == done_cyc) begin
                bad = 0;
                for (int k = 0; k < 256; k++)
                    if (mirror[{cur_buf, 8'(k)}] !== exp_ram[{cur_buf, 8'(k)}]) bad++;
                chk("line_ram_final_mismatches", 32'(bad), 32'd0);
            end
        end
        if (reset) begin
            for (int i = 0; i < NUM; i++) tbl[i] = 27'd0;
            exp_wr.delete();
            exp_rom.delete();
            active = 1'b0; done_cyc = -1; ovf_cyc = NEVER;
            started = 1'b1;
        end else begin
            if (sl_if.attr_we) tbl[sl_if.attr_addr] = sl_if.attr_wdata;
            if (sl_if.line_start) build(cyc, sl_if.next_row, sl_if.buf_sel);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wr(int i, bit en, int num, int y, int x);
        sl_if.attr_we = 1'b1;
        sl_if.attr_addr = 3'(i);
        sl_if.attr_wdata = {en, 6'(num), 10'(y), 10'(x)};
        tick();
        sl_if.attr_we = 1'b0;
    endtask

    task automatic start(int row, bit b, output int t);
        sl_if.line_start = 1'b1;
        sl_if.next_row = 10'(row);
        sl_if.buf_sel = b;
        t = cyc;
        tick();
        sl_if.line_start = 1'b0;
    endtask

    task automatic go_to(int c);
        while (cyc < c) tick();
    endtask

    task automatic wait_done(int budget, output int dc);
        dc = -1;
        for (int n = 0; n < budget; n++) begin
            if (sl_if.done === 1'b1) begin
                dc = cyc;
                break;
            end
            tick();
        end
        if (dc < 0) chk("done_within_budget", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    int t, dc, ds;
    initial begin
        sl_if.line_start = 1'b0; sl_if.next_row = 10'd0; sl_if.buf_sel = 1'b0;
        sl_if.attr_we = 1'b0; sl_if.attr_addr = 3'd0; sl_if.attr_wdata = 27'd0;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_busy", 32'(sl_if.busy), 32'd0);
        chk("reset_done", 32'(sl_if.done), 32'd0);
        chk("reset_lr_write", 32'(sl_if.lr_write), 32'd0);
        chk("reset_overflow", 32'(sl_if.overflow), 32'd0);
        chk("reset_rom_sprite", 32'(sl_if.rom_sprite), 32'd0);

        // 1: empty table, clear of upper half only
        start(0, 1'b1, t);
        chk("t1_first_clear_we", 32'(sl_if.lr_write), 32'd1);
        chk("t1_first_clear_addr", 32'(sl_if.lr_addr), 32'h100);
        wait_done(400, dc);
        chk("t1_done_cycle", 32'(dc - t), 32'd265);
        repeat (10) tick();

        // 2: single sprite, dy=7
        do_reset();
        wr(2, 1'b1, 5, 100, 40);
        start(107, 1'b0, t);
        go_to(t + 260);
        chk("t2_rom_sprite", 32'(sl_if.rom_sprite), 32'd5);
        chk("t2_rom_row", 32'(sl_if.rom_row), 32'd3);
        go_to(t + 262);
        chk("t2_col1_we", 32'(sl_if.lr_write), 32'd1);
        chk("t2_col1_addr", 32'(sl_if.lr_addr), 32'd21);
        chk("t2_col1_data", 32'(sl_if.lr_data), 32'd1);
        wait_done(400, dc);
        chk("t2_done_cycle", 32'(dc - t), 32'd274);

        // 3: row wraparound and x wrap within the half
        do_reset();
        wr(0, 1'b1, 1, 1020, 10);
        wr(1, 1'b1, 2, 0, 500);
        start(3, 1'b0, t);
        go_to(t + 275);
        chk("t3_col6_addr", 32'(sl_if.lr_addr), 32'd0);
        chk("t3_col6_data", 32'(sl_if.lr_data), 32'd1);
        tick();
        chk("t3_col7_addr", 32'(sl_if.lr_addr), 32'd1);
        chk("t3_col7_data", 32'(sl_if.lr_data), 32'd2);
        wait_done(400, dc);
        chk("t3_done_cycle", 32'(dc - t), 32'd283);

        // 4: six hits, only four rendered
        do_reset();
        for (int i = 0; i < 6; i++) wr(i, 1'b1, i, 50, i * 16);
        start(50, 1'b1, t);
        go_to(t + 297);
        chk("t4_ovf_before", 32'(sl_if.overflow), 32'd0);
        tick();
        chk("t4_ovf_after", 32'(sl_if.overflow), 32'd1);
        wait_done(400, dc);
        chk("t4_done_cycle", 32'(dc - t), 32'd301);
        chk("t4_ovf_held", 32'(sl_if.overflow), 32'd1);
        start(900, 1'b1, t);
        chk("t4_ovf_cleared", 32'(sl_if.overflow), 32'd0);
        wait_done(400, dc);

        // 5: overlap priority and transparency
        do_reset();
        wr(0, 1'b1, 1, 200, 60);
        wr(1, 1'b1, 2, 200, 60);
        start(200, 1'b0, t);
        wait_done(400, dc);
        tick();
        chk("t5_addr30_later_wins", 32'(mirror[30]), 32'd2);
        chk("t5_addr32_transparent", 32'(mirror[32]), 32'd3);

        // 6a: restart mid-build
        do_reset();
        wr(0, 1'b1, 3, 10, 0);
        start(10, 1'b0, t);
        go_to(t + 100);
        ds = done_seen;
        start(10, 1'b1, t);
        chk("t6_restart_addr", 32'(sl_if.lr_addr), 32'h100);
        chk("t6_restart_we", 32'(sl_if.lr_write), 32'd1);
        wait_done(400, dc);
        chk("t6_done_cycle", 32'(dc - t), 32'd274);
        tick();
        chk("t6_single_done", 32'(done_seen - ds), 32'd1);

        // 6b: reset during FETCH
        start(10, 1'b0, t);
        go_to(t + 260);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_lr_write", 32'(sl_if.lr_write), 32'd0);
        chk("t6_rst_busy", 32'(sl_if.busy), 32'd0);
        chk("t6_rst_done", 32'(sl_if.done), 32'd0);
        ds = done_seen;
        repeat (30) tick();
        chk("t6_rst_no_done", 32'(done_seen - ds), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end
endmodule
